// File: rtl/mips_bus_bridge.sv
// rtl/mips_bus_bridge.sv - merges instruction and data ports onto one Avalon-style bus
// Fixed-priority arbiter, registered bus request, one-cycle valid pulses, wait-state watchdog.
module mips_bus_bridge #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_req,
  input  logic [ADDR_W-1:0]     instr_address,
  output logic [DATA_W-1:0]     instr_readdata,
  output logic                  instr_valid,
  input  logic                  data_read,
  input  logic                  data_write,
  input  logic [ADDR_W-1:0]     data_address,
  input  logic [DATA_W-1:0]     data_writedata,
  input  logic [DATA_W/8-1:0]   data_byteenable,
  output logic [DATA_W-1:0]     data_readdata,
  output logic                  data_valid,
  output logic                  stall,
  output logic [ADDR_W-1:0]     address,
  output logic                  read,
  output logic                  write,
  output logic [DATA_W-1:0]     writedata,
  output logic [DATA_W/8-1:0]   byteenable,
  input  logic                  waitrequest,
  input  logic [DATA_W-1:0]     readdata,
  output logic                  bus_error
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_STORE,
    S_ERROR
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [ADDR_W-1:0]   r_address;
  logic                r_read;
  logic                r_write;
  logic [DATA_W-1:0]   r_writedata;
  logic [BE_W-1:0]     r_byteenable;
  logic [DATA_W-1:0]   r_instr_readdata;
  logic [DATA_W-1:0]   r_data_readdata;
  logic                r_instr_valid;
  logic                r_data_valid;
  logic                r_bus_error;

  logic                w_instr_pend;
  logic                w_data_pend;
  logic [ADDR_W-1:0]   w_word_mask;

  // A request whose valid is pulsing this cycle is already served; the core
  // drops it on the next edge, so it must not be re-issued from IDLE.
  assign w_instr_pend = instr_req & ~r_instr_valid;
  assign w_data_pend  = (data_read | data_write) & ~r_data_valid;
  assign w_word_mask  = ~ADDR_W'(BE_W - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_wait_cnt       <= '0;
      r_address        <= '0;
      r_read           <= 1'b0;
      r_write          <= 1'b0;
      r_writedata      <= '0;
      r_byteenable     <= '0;
      r_instr_readdata <= '0;
      r_data_readdata  <= '0;
      r_instr_valid    <= 1'b0;
      r_data_valid     <= 1'b0;
      r_bus_error      <= 1'b0;
    end else begin
      r_instr_valid <= 1'b0;
      r_data_valid  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wait_cnt <= '0;
          if (w_data_pend && data_write) begin
            r_state      <= S_STORE;
            r_address    <= data_address & w_word_mask;
            r_writedata  <= data_writedata;
            r_byteenable <= data_byteenable;
            r_write      <= 1'b1;
          end else if (w_data_pend) begin
            r_state      <= S_LOAD;
            r_address    <= data_address & w_word_mask;
            r_byteenable <= {BE_W{1'b1}};
            r_read       <= 1'b1;
          end else if (w_instr_pend) begin
            r_state      <= S_FETCH;
            r_address    <= instr_address & w_word_mask;
            r_byteenable <= {BE_W{1'b1}};
            r_read       <= 1'b1;
          end
        end
        S_FETCH, S_LOAD, S_STORE: begin
          if (!waitrequest) begin
            r_state    <= S_IDLE;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_wait_cnt <= '0;
            if (r_state == S_FETCH) begin
              r_instr_readdata <= readdata;
              r_instr_valid    <= 1'b1;
            end else begin
              if (r_state == S_LOAD) r_data_readdata <= readdata;
              r_data_valid <= 1'b1;
            end
          end else if (r_wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
            r_state     <= S_ERROR;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_bus_error <= 1'b1;
            r_wait_cnt  <= CNT_W'(MAX_WAIT);
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_ERROR: begin
          r_read  <= 1'b0;
          r_write <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign address        = r_address;
  assign read           = r_read;
  assign write          = r_write;
  assign writedata      = r_writedata;
  assign byteenable     = r_byteenable;
  assign instr_readdata = r_instr_readdata;
  assign data_readdata  = r_data_readdata;
  assign instr_valid    = r_instr_valid;
  assign data_valid     = r_data_valid;
  assign bus_error      = r_bus_error;
  // Gated by reset so every output reads 0 while reset is held.
  assign stall          = reset & (w_instr_pend | w_data_pend | (r_state == S_ERROR));

endmodule

// File: tb/tb_mips_bus_bridge.sv
// tb/tb_mips_bus_bridge.sv - self-checking bench for mips_bus_bridge
// Vector table plus scoreboard queues for valid pulses and bus requests.
module tb_mips_bus_bridge;

  logic        clk;
  logic        reset;
  logic        instr_req;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        instr_valid;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_address;
  logic [31:0] data_writedata;
  logic [3:0]  data_byteenable;
  logic [31:0] data_readdata;
  logic        data_valid;
  logic        stall;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        bus_error;

  mips_bus_bridge #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .instr_req(instr_req), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .instr_valid(instr_valid),
    .data_read(data_read), .data_write(data_write), .data_address(data_address),
    .data_writedata(data_writedata), .data_byteenable(data_byteenable),
    .data_readdata(data_readdata), .data_valid(data_valid), .stall(stall),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
    .bus_error(bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_instr;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    int          nwait;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    int          exp_lat;
  } vec_t;

  typedef struct {
    bit          is_instr;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Slave model: holds waitrequest for sl_nwait strobe cycles, then accepts.
  int          sl_cnt = 0;
  int          sl_nwait = 0;
  bit          sl_fn = 0;
  logic [31:0] sl_rdata = '0;
  logic [31:0] last_instr_rd = '0;
  logic [31:0] last_data_rd = '0;

  assign waitrequest = (read || write) && (sl_cnt < sl_nwait);
  assign readdata    = sl_fn ? (address ^ 32'hA5A5A5A5) : sl_rdata;

  always @(posedge clk) begin
    if (!(read || write) || !waitrequest) sl_cnt <= 0;
    else sl_cnt <= sl_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bus_t b;
    chk("strobe_overlap", 32'(read && write), 32'd0);
    if (instr_valid || data_valid) begin
      chk("valid_overlap", 32'(instr_valid && data_valid), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("valid_port", 32'(instr_valid), 32'(e.is_instr));
        if (e.chk_data) chk("readdata", e.is_instr ? instr_readdata : data_readdata, e.data);
      end
    end
    if (read || write) begin
      if (bus_q.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        b = bus_q[0];
        chk("bus_write", 32'(write), 32'(b.wr));
        chk("bus_address", address, b.addr);
        chk("bus_byteenable", 32'(byteenable), 32'(b.be));
        if (b.wr) chk("bus_writedata", writedata, b.wdata);
        if (!waitrequest) void'(bus_q.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    instr_req = 0; data_read = 0; data_write = 0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    bus_t b;
    int vcyc, strobes, stall_bad;
    sl_fn = 0; sl_rdata = v.rdata; sl_nwait = v.nwait;
    e.is_instr = v.is_instr; e.chk_data = !v.wr; e.data = v.rdata;
    exp_q.push_back(e);
    b.wr = v.wr; b.addr = v.exp_addr; b.wdata = v.wdata; b.be = v.exp_be;
    bus_q.push_back(b);
    @(posedge clk); #1;
    if (v.is_instr) begin
      instr_req = 1; instr_address = v.addr;
    end else begin
      data_read = v.rd; data_write = v.wr; data_address = v.addr;
      data_writedata = v.wdata; data_byteenable = v.be;
    end
    vcyc = -1; strobes = 0; stall_bad = 0;
    for (int c = 0; c < 40 && vcyc < 0; c++) begin
      @(negedge clk);
      if (read || write) strobes++;
      if (v.is_instr ? instr_valid : data_valid) begin
        vcyc = c;
        chk("stall_on_valid", 32'(stall), 32'd0);
      end else if (!stall) begin
        stall_bad++;
      end
    end
    chk("latency", 32'(vcyc), 32'(v.exp_lat));
    chk("strobe_cycles", 32'(strobes), 32'(v.nwait + 1));
    chk("stall_while_pending", 32'(stall_bad), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    if (v.is_instr) last_instr_rd = v.rdata;
    else if (!v.wr) last_data_rd = v.rdata;
    chk("instr_readdata_hold", instr_readdata, last_instr_rd);
    chk("data_readdata_hold", data_readdata, last_data_rd);
  endtask

  vec_t vecs[6];

  initial begin
    exp_t e;
    bus_t b;
    int dv, iv, fs, ec;

    vecs[0] = '{1, 0, 0, 32'hBFC00003, 32'h0, 4'h0, 32'h24020005, 0, 32'hBFC00000, 4'hF, 2};
    vecs[1] = '{0, 0, 1, 32'h00001004, 32'hDEADBEEF, 4'b0011, 32'h0, 3, 32'h00001004, 4'b0011, 5};
    vecs[2] = '{0, 1, 0, 32'h00002002, 32'h0, 4'h0, 32'h12345678, 1, 32'h00002000, 4'hF, 3};
    vecs[3] = '{0, 1, 1, 32'h0000300F, 32'hCAFEF00D, 4'b1000, 32'h11111111, 0, 32'h0000300C, 4'b1000, 2};
    vecs[4] = '{1, 0, 0, 32'h00400004, 32'h0, 4'h0, 32'h8FA20000, 2, 32'h00400004, 4'hF, 4};
    vecs[5] = '{0, 1, 0, 32'hFFFFFFFD, 32'h0, 4'h0, 32'hA5A55A5A, 0, 32'hFFFFFFFC, 4'hF, 2};

    reset = 0; idle_inputs();
    instr_address = '0; data_address = '0; data_writedata = '0; data_byteenable = '0;
    repeat (2) @(negedge clk);
    chk("rst_read", 32'(read), 0);
    chk("rst_write", 32'(write), 0);
    chk("rst_address", address, 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_bus_error", 32'(bus_error), 0);
    chk("rst_valids", 32'({instr_valid, data_valid}), 0);
    chk("rst_readdata", instr_readdata | data_readdata, 0);
    reset = 1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_vec(vecs[i]);
      @(posedge clk); #1;
    end

    // Fetch and load together: load wins, fetch issued the cycle after data_valid.
    sl_fn = 1; sl_nwait = 0;
    e = '{0, 1, 32'h00007008 ^ 32'hA5A5A5A5}; exp_q.push_back(e);
    e = '{1, 1, 32'h00400010 ^ 32'hA5A5A5A5}; exp_q.push_back(e);
    b = '{0, 32'h00007008, 32'h0, 4'hF}; bus_q.push_back(b);
    b = '{0, 32'h00400010, 32'h0, 4'hF}; bus_q.push_back(b);
    @(posedge clk); #1;
    instr_req = 1; instr_address = 32'h00400013;
    data_read = 1; data_address = 32'h0000700A;
    dv = -1; iv = -1; fs = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (data_valid && dv < 0) dv = c;
      if (instr_valid && iv < 0) iv = c;
      if (read && address == 32'h00400010 && fs < 0) fs = c;
      @(posedge clk); #1;
      if (dv == c) data_read = 0;
      if (iv == c) instr_req = 0;
    end
    chk("simul_data_valid_cyc", 32'(dv), 2);
    chk("simul_fetch_strobe_cyc", 32'(fs), 3);
    chk("simul_instr_valid_cyc", 32'(iv), 4);
    last_instr_rd = 32'h00400010 ^ 32'hA5A5A5A5;
    last_data_rd  = 32'h00007008 ^ 32'hA5A5A5A5;
    chk("simul_queue_drained", 32'(exp_q.size()), 0);

    // Reset in the middle of a load with wait states.
    sl_fn = 0; sl_rdata = 32'h99999999; sl_nwait = 3;
    b = '{0, 32'h00005000, 32'h0, 4'hF}; bus_q.push_back(b);
    @(posedge clk); #1;
    data_read = 1; data_address = 32'h00005000;
    repeat (2) @(negedge clk);
    chk("pre_reset_read", 32'(read), 1);
    #2 reset = 0;
    #1;
    chk("mid_rst_read", 32'(read), 0);
    chk("mid_rst_address", address, 0);
    chk("mid_rst_stall", 32'(stall), 0);
    chk("mid_rst_readdata", instr_readdata | data_readdata, 0);
    exp_q.delete(); bus_q.delete();
    dv = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (data_valid) dv++;
    end
    chk("mid_rst_no_valid", 32'(dv), 0);
    #1 reset = 1; idle_inputs();
    last_instr_rd = '0; last_data_rd = '0;
    run_vec(vecs[0]);
    @(posedge clk); #1;

    // Watchdog: waitrequest never released.
    sl_fn = 0; sl_nwait = 1000;
    b = '{0, 32'h00006000, 32'h0, 4'hF}; bus_q.push_back(b);
    @(posedge clk); #1;
    data_read = 1; data_address = 32'h00006000;
    ec = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus_error && ec < 0) begin
        ec = c;
        chk("wdog_strobes_drop", 32'({read, write}), 0);
      end
      @(posedge clk); #1;
      if (c == 8) data_read = 0;
    end
    chk("wdog_error_cyc", 32'(ec), 5);
    chk("wdog_stall_held", 32'(stall), 1);
    chk("wdog_bus_error_sticky", 32'(bus_error), 1);
    chk("wdog_no_strobe", 32'({read, write}), 0);
    reset = 0; #1;
    chk("wdog_rst_bus_error", 32'(bus_error), 0);
    chk("wdog_rst_stall", 32'(stall), 0);
    exp_q.delete(); bus_q.delete();
    @(negedge clk); reset = 1;
    repeat (2) @(posedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mips_bus_bridge.md
# mips_bus_bridge

Parametrised bridge that merges the CPU core's separate instruction and data ports onto a single Avalon-style memory bus with `waitrequest`, for the bus-interface generation of the MIPS CPU. It arbitrates between fetch and load/store requests and registers the bus request. It returns read data to the requesting port with a one-cycle valid pulse, and stalls the core while any access is outstanding. A wait-state watchdog flags a bus that never releases `waitrequest`.

## Interface
- `DATA_W`, 32: bus and core data width; multiple of 8.
- `ADDR_W`, 32: byte-address width.
- `MAX_WAIT`, 255: maximum consecutive cycles `waitrequest` may stay high before `bus_error`; ≥1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `instr_req` in 1: core requests an instruction fetch; held until `instr_valid`.
- `instr_address` in ADDR_W: fetch byte address.
- `instr_readdata` out DATA_W: fetched word; valid while `instr_valid`=1.
- `instr_valid` out 1: one-cycle pulse, fetch complete.
- `data_read` in 1: load request; held until `data_valid`.
- `data_write` in 1: store request; held until `data_valid`.
- `data_address` in ADDR_W: load/store byte address.
- `data_writedata` in DATA_W: store data.
- `data_byteenable` in DATA_W/8: store lane enables.
- `data_readdata` out DATA_W: load result; valid while `data_valid`=1.
- `data_valid` out 1: one-cycle pulse, load or store complete.
- `stall` out 1: core must not advance.
- `address` out ADDR_W: bus word address.
- `read` out 1: bus read strobe.
- `write` out 1: bus write strobe.
- `writedata` out DATA_W: bus write data.
- `byteenable` out DATA_W/8: bus lane enables.
- `waitrequest` in 1: slave not ready; current request must be held.
- `readdata` in DATA_W: bus read data, sampled when `read`=1 and `waitrequest`=0.
- `bus_error` out 1: sticky watchdog flag.

## Operation
- FSM states:
  - IDLE: no bus request issued.
  - FETCH: fetch request on the bus.
  - LOAD: load request on the bus.
  - STORE: store request on the bus.
  - ERROR: watchdog has tripped.
- IDLE arbitration, evaluated each cycle; priority `data_write` > `data_read` > `instr_req`.
  - A data access pending together with a fetch wins.
  - The fetch is served on the following transaction.
- Entering FETCH, LOAD or STORE registers the bus outputs:
  - `address` = request address with bits [log2(DATA_W/8)-1:0] forced to 0.
  - FETCH and LOAD drive `byteenable` all-ones.
  - STORE drives `data_byteenable` and `data_writedata`.
- In a bus state, strobes and payload are held constant while `waitrequest`=1.
- On the first cycle with `waitrequest`=0:
  - Completion is accepted; the FSM returns to IDLE.
  - The matching valid pulses on the next cycle.
  - For reads, `readdata` is captured into `instr_readdata` or `data_readdata`.
- Read-data registers hold their value until the next completion on the same port.
- `data_read` and `data_write` asserted together: treated as a store; a load is not issued.
- Requests deasserted by the core before completion: the bus transaction still completes, and the valid still pulses.
- Watchdog:
  - A counter increments each cycle in a bus state with `waitrequest`=1, and clears on completion or in IDLE.
  - When the counter reaches MAX_WAIT the FSM enters ERROR, which sets `bus_error` and drops the strobes.
  - ERROR holds `stall`=1 and is left only by reset.
- `stall` = (any request input high and the matching valid not being pulsed this cycle) or state == ERROR.

## Timing
- Reset (`reset`=0, asynchronous): state IDLE, watchdog counter 0, and all outputs 0:
  - `read`, `write`, `address`, `writedata`, `byteenable`;
  - `instr_valid`, `data_valid`, `instr_readdata`, `data_readdata`;
  - `bus_error`, `stall`.
- Reset mid-transaction aborts it; no valid pulse is produced.
- Reset deassertion takes effect on the next rising edge.
- Latency with zero wait states:
  - Request seen in IDLE at edge N; strobe high after N.
  - `waitrequest`=0 sampled at N+1.
  - Valid high after N+1, i.e. two cycles from request to valid.
- Each wait cycle adds one cycle of latency.
- Back-to-back: IDLE is re-entered on the valid cycle, so the next request is issued one cycle after the valid. Minimum is 3 cycles per transaction.
- Strobes are never high in IDLE or ERROR.
- At most one of `read`/`write` is high at any time.
- `instr_valid` and `data_valid` are never high in the same cycle.

## Test plan
- Zero-wait fetch:
  - Stimulus: `instr_req`=1, `instr_address`=0xBFC00003, `readdata`=0x24020005.
  - Required: `address`=0xBFC00000 with `read`=1 for 1 cycle; `instr_valid` pulses 2 cycles after the request with `instr_readdata`=0x24020005.
- Store with 3 wait states:
  - Stimulus: `data_write`=1, `data_address`=0x1004, `data_writedata`=0xDEADBEEF, `data_byteenable`=0b0011.
  - Required: `write`/`address`/`writedata`/`byteenable` stable for 4 cycles; `data_valid` 5 cycles after the request; `stall`=1 throughout.
- Simultaneous fetch and load:
  - Stimulus: `instr_req` and `data_read` asserted together.
  - Required: load on the bus first, `data_valid` first; fetch issued 1 cycle later; no overlapping strobes.
- Watchdog:
  - Stimulus: MAX_WAIT=4, `waitrequest` held at 1.
  - Required: `bus_error`=1 after 4 wait cycles; strobes drop to 0; `stall` stays 1 until `reset`=0.
- Reset mid-operation:
  - Stimulus: assert `reset`=0 during a load with waits.
  - Required: outputs 0 immediately (asynchronously), no `data_valid`; after release, a new fetch completes normally.
